// File: rtl/regfile_wb_arb_if.sv
// Write-back bus between requesters, the arbiter and the register file.
//   slave  : arbiter view; takes requests and rf_ready, drives req_ready and the rf_* write port
//   master : environment view; drives requests and rf_ready, observes the arbiter outputs
// Signals:
//   req_valid/req_ready  per-requester handshake (bit i = requester i)
//   req_idx/req_data     packed per-requester destination index and data (slice i)
//   rf_wen/rf_widx/rf_wdat/rf_ready  register-file write port and its accept
//   grant_id             requester id held in the output stage
//   wb_cnt               saturating count of writes consumed by the register file
interface regfile_wb_arb_if #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned DW   = 32,
  parameter int unsigned AW   = 5
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*AW-1:0] req_idx;
  logic [NREQ*DW-1:0] req_data;
  logic               rf_wen;
  logic [AW-1:0]      rf_widx;
  logic [DW-1:0]      rf_wdat;
  logic               rf_ready;
  logic [2:0]         grant_id;
  logic [15:0]        wb_cnt;

  modport slave (
    input  req_valid, req_idx, req_data, rf_ready,
    output req_ready, rf_wen, rf_widx, rf_wdat, grant_id, wb_cnt
  );

  modport master (
    output req_valid, req_idx, req_data, rf_ready,
    input  req_ready, rf_wen, rf_widx, rf_wdat, grant_id, wb_cnt
  );
endinterface

// File: rtl/regfile_wb_arb.sv
// Register-file write-back arbiter. Up to eight requesters compete for one register-file write
// port through a single-entry output stage. Requester 0 optionally has strict priority; the rest
// (or all of them) share a round-robin pool. Writes to index 0 are accepted and discarded.
// Ports:
//   clk  : clock, all state on the rising edge
//   rst  : asynchronous active-high reset
//   bus  : regfile_wb_arb_if.slave (requests in, register-file write port out)
module regfile_wb_arb #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned DW      = 32,
  parameter int unsigned AW      = 5,
  parameter int unsigned HIPRIO0 = 1
) (
  input logic             clk,
  input logic             rst,
  regfile_wb_arb_if.slave bus
);

  // Round-robin pool is [PoolLo, NREQ-1]
  localparam int unsigned PoolLo  = (HIPRIO0 != 0) ? 1 : 0;
  localparam int unsigned PoolSz  = NREQ - PoolLo;
  localparam logic [3:0]  NreqW   = 4'(NREQ);
  localparam logic [3:0]  PoolLoW = 4'(PoolLo);
  localparam logic [3:0]  PoolSzW = 4'(PoolSz);

  logic          ovld_q;
  logic [AW-1:0] oidx_q;
  logic [DW-1:0] odat_q;
  logic [2:0]    oid_q;
  logic [15:0]   wb_cnt_q;
  logic [2:0]    rr_ptr_q;

  logic [7:0]      valid_pad;
  logic            win_vld;
  logic [2:0]      win_id;
  logic [3:0]      cand;
  logic            can_load;
  logic            take;
  logic            pool_take;
  logic [3:0]      rr_nxt;
  logic [NREQ-1:0] ready;
  logic [AW-1:0]   sel_idx;
  logic [DW-1:0]   sel_dat;
  logic            drain;

  assign valid_pad = 8'(bus.req_valid);

  // Winner selection depends only on req_valid and rr_ptr; data/index never feed req_ready.
  always_comb begin
    win_vld = 1'b0;
    win_id  = 3'd0;
    cand    = 4'd0;
    if ((HIPRIO0 != 0) && bus.req_valid[0]) begin
      win_vld = 1'b1;
      win_id  = 3'd0;
    end else begin
      for (int k = 0; k < PoolSz; k++) begin
        cand = {1'b0, rr_ptr_q} + 4'(k);
        if (cand >= NreqW) cand = cand - PoolSzW;
        if (!win_vld && valid_pad[cand[2:0]]) begin
          win_vld = 1'b1;
          win_id  = cand[2:0];
        end
      end
    end
  end

  // Stage refills in the same cycle it drains, so back-to-back writes have no bubble.
  assign can_load  = !ovld_q || bus.rf_ready;
  assign take      = win_vld && can_load && !rst;
  assign pool_take = take && !((HIPRIO0 != 0) && (win_id == 3'd0));
  assign drain     = ovld_q && bus.rf_ready;

  always_comb begin
    rr_nxt = {1'b0, win_id} + 4'd1;
    if (rr_nxt >= NreqW) rr_nxt = PoolLoW;
  end

  always_comb begin
    ready   = '0;
    sel_idx = '0;
    sel_dat = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_id == 3'(i)) begin
        ready[i] = take;
        sel_idx  = bus.req_idx[i*AW +: AW];
        sel_dat  = bus.req_data[i*DW +: DW];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovld_q   <= 1'b0;
      oidx_q   <= '0;
      odat_q   <= '0;
      oid_q    <= 3'd0;
      wb_cnt_q <= 16'd0;
      rr_ptr_q <= 3'(PoolLo);
    end else begin
      if (drain && (wb_cnt_q != 16'hFFFF)) wb_cnt_q <= wb_cnt_q + 16'd1;
      if (can_load) begin
        // An accepted write to x0 is swallowed: the stage empties instead of loading.
        if (take && (sel_idx != '0)) begin
          ovld_q <= 1'b1;
          oidx_q <= sel_idx;
          odat_q <= sel_dat;
          oid_q  <= win_id;
        end else begin
          ovld_q <= 1'b0;
        end
      end
      if (pool_take) rr_ptr_q <= rr_nxt[2:0];
    end
  end

  assign bus.req_ready = ready;
  assign bus.rf_wen    = ovld_q;
  assign bus.rf_widx   = oidx_q;
  assign bus.rf_wdat   = odat_q;
  assign bus.grant_id  = oid_q;
  assign bus.wb_cnt    = wb_cnt_q;

  a_ready_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(bus.req_ready));

endmodule

// File: tb/tb_regfile_wb_arb.sv
// Directed bench for regfile_wb_arb (NREQ=4, DW=32, AW=5, HIPRIO0=1).
module tb_regfile_wb_arb;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  regfile_wb_arb_if #(.NREQ(4), .DW(32), .AW(5)) bus ();

  regfile_wb_arb #(
    .NREQ   (4),
    .DW     (32),
    .AW     (5),
    .HIPRIO0(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [4:0] idx, input logic [31:0] dat);
    bus.req_idx[i*5 +: 5]   = idx;
    bus.req_data[i*32 +: 32] = dat;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req_valid = '0;
    #1;
    tick();
    rst = 1'b0;
    #1;
  endtask

  int order [6] = '{1, 2, 3, 1, 2, 3};

  initial begin
    rst           = 1'b1;
    bus.req_valid = 4'b1111;
    bus.req_idx   = '0;
    bus.req_data  = '0;
    bus.rf_ready  = 1'b0;
    tick();
    check("rst_ready", 32'(bus.req_ready), 32'h0);
    check("rst_wen",   32'(bus.rf_wen),    32'h0);
    check("rst_cnt",   32'(bus.wb_cnt),    32'h0);
    check("rst_gid",   32'(bus.grant_id),  32'h0);
    check("rst_widx",  32'(bus.rf_widx),   32'h0);
    check("rst_wdat",  bus.rf_wdat,        32'h0);
    rst = 1'b0;
    bus.req_valid = '0;

    // Single write from requester 1
    bus.rf_ready = 1'b1;
    set_req(1, 5'd7, 32'hDEADBEEF);
    bus.req_valid = 4'b0010;
    #1;
    check("single_ready", 32'(bus.req_ready), 32'h2);
    tick();
    bus.req_valid = '0;
    #1;
    check("single_wen",  32'(bus.rf_wen),   32'h1);
    check("single_widx", 32'(bus.rf_widx),  32'h7);
    check("single_wdat", bus.rf_wdat,       32'hDEADBEEF);
    check("single_gid",  32'(bus.grant_id), 32'h1);
    tick();
    check("single_cnt",  32'(bus.wb_cnt),   32'h1);
    check("single_idle", 32'(bus.rf_wen),   32'h0);

    // Round-robin among 1..3 from a fresh pointer
    do_reset();
    for (int i = 1; i < 4; i++) set_req(i, 5'(i + 4), 32'h100 + 32'(i));
    bus.rf_ready  = 1'b1;
    bus.req_valid = 4'b1110;
    #1;
    for (int c = 0; c < 6; c++) begin
      check("rr_ready", 32'(bus.req_ready), 32'h1 << order[c]);
      tick();
      check("rr_gid",  32'(bus.grant_id), 32'(order[c]));
      check("rr_wdat", bus.rf_wdat,       32'h100 + 32'(order[c]));
    end
    bus.req_valid = '0;
    tick();
    check("rr_cnt",  32'(bus.wb_cnt), 32'd6);
    check("rr_idle", 32'(bus.rf_wen), 32'h0);

    // Priority: move pointer to 2 first, then requester 0 must not disturb it
    set_req(0, 5'd4, 32'hA0A0A0A0);
    bus.req_valid = 4'b0010;
    #1;
    check("prio_pre", 32'(bus.req_ready), 32'h2);
    tick();
    bus.req_valid = 4'b1111;
    #1;
    for (int c = 0; c < 3; c++) begin
      check("prio_ready", 32'(bus.req_ready), 32'h1);
      tick();
      check("prio_gid", 32'(bus.grant_id), 32'h0);
    end
    bus.req_valid = 4'b1110;
    #1;
    check("prio_after", 32'(bus.req_ready), 32'h4);
    tick();
    check("prio_after_gid", 32'(bus.grant_id), 32'h2);
    bus.req_valid = '0;
    tick();
    check("prio_cnt", 32'(bus.wb_cnt), 32'd11);

    // Backpressure: entry A held four cycles, B accepted when rf_ready returns
    set_req(2, 5'd6, 32'hAAAA0001);
    bus.req_valid = 4'b0100;
    #1;
    check("bp_load_ready", 32'(bus.req_ready), 32'h4);
    tick();
    bus.rf_ready = 1'b0;
    set_req(2, 5'd10, 32'hBBBB0002);
    #1;
    for (int c = 0; c < 4; c++) begin
      check("bp_ready", 32'(bus.req_ready), 32'h0);
      check("bp_wen",   32'(bus.rf_wen),    32'h1);
      check("bp_widx",  32'(bus.rf_widx),   32'h6);
      check("bp_wdat",  bus.rf_wdat,        32'hAAAA0001);
      check("bp_gid",   32'(bus.grant_id),  32'h2);
      check("bp_cnt",   32'(bus.wb_cnt),    32'd11);
      tick();
    end
    bus.rf_ready = 1'b1;
    #1;
    check("bp_release_ready", 32'(bus.req_ready), 32'h4);
    tick();
    bus.req_valid = '0;
    #1;
    check("bp_b_wdat", bus.rf_wdat,      32'hBBBB0002);
    check("bp_b_widx", 32'(bus.rf_widx), 32'd10);
    tick();
    check("bp_cnt_end", 32'(bus.wb_cnt), 32'd13);

    // x0 write from requester 3 is accepted and dropped
    set_req(3, 5'd0, 32'h12345678);
    bus.req_valid = 4'b1000;
    #1;
    check("x0_ready", 32'(bus.req_ready), 32'h8);
    tick();
    bus.req_valid = '0;
    #1;
    check("x0_wen", 32'(bus.rf_wen), 32'h0);
    check("x0_cnt", 32'(bus.wb_cnt), 32'd13);

    // x0 accepted while the stage drains empties it
    set_req(1, 5'd9, 32'h55);
    bus.req_valid = 4'b0010;
    #1;
    tick();
    bus.req_valid = 4'b1000;
    #1;
    check("x0d_ready", 32'(bus.req_ready), 32'h8);
    check("x0d_full",  32'(bus.rf_wen),    32'h1);
    tick();
    bus.req_valid = '0;
    #1;
    check("x0d_wen", 32'(bus.rf_wen), 32'h0);
    check("x0d_cnt", 32'(bus.wb_cnt), 32'd14);

    // Asynchronous reset during a held write
    set_req(1, 5'd3, 32'h77);
    bus.req_valid = 4'b0010;
    #1;
    tick();
    bus.req_valid = '0;
    bus.rf_ready  = 1'b0;
    tick();
    check("ar_hold_wen", 32'(bus.rf_wen), 32'h1);
    #2;
    rst = 1'b1;
    bus.req_valid = 4'b1111;
    #1;
    check("ar_wen",   32'(bus.rf_wen),    32'h0);
    check("ar_cnt",   32'(bus.wb_cnt),    32'h0);
    check("ar_ready", 32'(bus.req_ready), 32'h0);
    check("ar_gid",   32'(bus.grant_id),  32'h0);
    #2;
    rst = 1'b0;
    bus.req_valid = 4'b1110;
    bus.rf_ready  = 1'b1;
    #1;
    check("ar_first_ready", 32'(bus.req_ready), 32'h2);
    tick();
    bus.req_valid = '0;
    #1;
    check("ar_first_gid",  32'(bus.grant_id), 32'h1);
    check("ar_first_wdat", bus.rf_wdat,       32'h77);
    tick();
    check("ar_first_cnt",  32'(bus.wb_cnt),   32'h1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arb.md
REGFILE_WB_ARB -- requirements
Module: regfile_wb_arb

Interface
REQ-001 Parameter NREQ, default 4: number of write-back requesters (2..8).
REQ-002 Parameter DW, default 32: write data width.
REQ-003 Parameter AW, default 5: register index width.
REQ-004 Parameter HIPRIO0, default 1: 1 gives requester 0 strict priority; 0 puts requester 0 in the round-robin pool.
REQ-005 clk  input  1  single clock; all state on its rising edge.
REQ-006 rst  input  1  reset, asynchronous and active-high.
REQ-007 req_valid  input  NREQ  requester i presents a write.
REQ-008 req_ready  output  NREQ  write from requester i accepted this cycle.
REQ-009 req_idx  input  NREQ*AW  destination index, slice i for requester i.
REQ-010 req_data  input  NREQ*DW  write data, slice i for requester i.
REQ-011 rf_wen  output  1  register-file write strobe (valid of the output stage).
REQ-012 rf_widx  output  AW  register-file write index.
REQ-013 rf_wdat  output  DW  register-file write data.
REQ-014 rf_ready  input  1  register file consumes the write this cycle.
REQ-015 grant_id  output  3  requester id held in the output stage.
REQ-016 wb_cnt  output  16  saturating count of writes consumed by the register file.

Function
REQ-017 Transfer on requester i occurs when req_valid[i] and req_ready[i] are both high in the same cycle.
REQ-018 Output-stage transfer occurs when rf_wen and rf_ready are both high in the same cycle.
REQ-019 Output stage is one entry (ovld, oidx, odat, oid); rf_wen is driven by ovld; rf_widx, rf_wdat and grant_id come from the entry.
REQ-020 Stage can load when ovld is 0 or rf_ready is 1 (pass-through refill with no bubble).
REQ-021 At most one req_ready bit is high per cycle, and only when the stage can load and that requester is the winner.
REQ-022 Winner with HIPRIO0=1: requester 0 if valid; otherwise round-robin among requesters 1..NREQ-1.
REQ-023 Winner with HIPRIO0=0: round-robin among requesters 0..NREQ-1.
REQ-024 Round-robin pointer rr_ptr: search starts at rr_ptr and wraps modulo the pool; pointer reset value is the lowest pool member.
REQ-025 rr_ptr updates only on a transfer from a pool member: rr_ptr becomes winner+1, wrapping to the lowest pool member.
REQ-026 A requester-0 grant under HIPRIO0=1 leaves rr_ptr unchanged.
REQ-027 Latency: a request accepted in cycle N appears on rf_wen in cycle N+1.
REQ-028 Output holds: while rf_wen=1 and rf_ready=0, rf_widx, rf_wdat and grant_id are stable and all req_ready bits are 0.
REQ-029 An accepted write with idx 0 (x0) is consumed; the output stage is not loaded and wb_cnt is not incremented.
REQ-030 If an x0 write is accepted while the stage drains (rf_ready=1), ovld falls to 0 the next cycle.
REQ-031 wb_cnt increments by 1 on each output-stage transfer and saturates at 16'hFFFF.
REQ-032 A requester dropping req_valid without a transfer is legal; arbitration is re-evaluated every cycle, and no grant lock exists.
REQ-033 req_ready is combinational from req_valid, rr_ptr, ovld and rf_ready; no combinational path exists from req_data or req_idx to req_ready.

Reset
REQ-034 While rst=1: ovld=0, rf_wen=0, oidx=0, odat=0, oid=0, wb_cnt=0, rr_ptr=lowest pool member, req_ready=0.
REQ-035 Reset asserted mid-operation discards any pending output entry immediately, without waiting for a clock edge; no write is issued after reset.
REQ-036 First transfer is possible in the first cycle after rst deasserts.

Verification
REQ-037 Single write: rf_ready=1, req_valid=4'b0010, idx=7, data=32'hDEADBEEF -> req_ready=4'b0010 in cycle 0; cycle 1: rf_wen=1, rf_widx=7, rf_wdat=DEADBEEF, grant_id=1; wb_cnt=1.
REQ-038 Round-robin fairness: HIPRIO0=1, req_valid=4'b1110 held for 6 cycles, rf_ready=1 -> grant order 1,2,3,1,2,3; wb_cnt=6.
REQ-039 Priority: req_valid=4'b1111 for 3 cycles -> requester 0 granted every cycle; rr_ptr unchanged (next grant after req 0 drops is 1).
REQ-040 Backpressure: output loaded, rf_ready=0 for 4 cycles with req_valid=4'b0100 -> req_ready=0 and rf_* stable for 4 cycles; req 2 accepted in the cycle rf_ready rises.
REQ-041 x0 drop: write idx=0 from req 3 -> req_ready[3]=1, rf_wen stays 0, wb_cnt unchanged.
REQ-042 Reset mid-hold: ovld=1, rf_ready=0, rst pulsed asynchronously between edges -> rf_wen=0 immediately, wb_cnt=0, next grant goes to requester 1.
